// File: rtl/sprite_datapath.sv
// Sweeps one sprite's pixels row-major and moves its position with screen wrap.
// Latency: one pixel per enabled clock, done in cycle SPRITE_W*SPRITE_H; move visible next cycle.
// Backpressure: none; control holds enable for the sweep and drops it (or retargets) on done.
module sprite_datapath #(
  parameter int          SPRITE_W = 27,
  parameter int          SPRITE_H = 17,
  parameter int          X_INIT   = 0,
  parameter int          Y_INIT   = 100,
  parameter int          DX       = 1,
  parameter int          DY       = 0,
  parameter int          SCREEN_W = 320,
  parameter int          SCREEN_H = 240,
  parameter logic [2:0]  COLOUR   = 3'b100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       can_move,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [8:0] x_final,
  output logic [7:0] y_final,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [5:0]         LAST_CX = 6'(SPRITE_W - 1);
  localparam logic [5:0]         LAST_CY = 6'(SPRITE_H - 1);
  localparam logic [9:0]         SCR_W10 = 10'(SCREEN_W);
  localparam logic [9:0]         SCR_H10 = 10'(SCREEN_H);
  localparam logic [8:0]         X_RST   = 9'(X_INIT);
  localparam logic [7:0]         Y_RST   = 8'(Y_INIT);
  localparam logic signed [10:0] DX_S    = 11'(DX);
  localparam logic signed [10:0] DY_S    = 11'(DY);
  localparam logic signed [10:0] SW_S    = 11'(SCREEN_W);
  localparam logic signed [10:0] SH_S    = 11'(SCREEN_H);

  logic [5:0]         cx_q, cx_d, cy_q, cy_d;
  logic [8:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [9:0]         x_sum, y_sum;
  logic signed [10:0] x_raw, y_raw;
  logic [8:0]         x_wrap;
  logic [7:0]         y_wrap;

  // Pixel address is widened so off-screen pixels past 511/255 still clip correctly.
  assign x_sum   = {1'b0, x_q} + {4'b0000, cx_q};
  assign y_sum   = {2'b00, y_q} + {4'b0000, cy_q};
  assign x_final = x_sum[8:0];
  assign y_final = y_sum[7:0];
  assign plot    = enable && (x_sum < SCR_W10) && (y_sum < SCR_H10);
  assign done    = enable && (cx_q == LAST_CX) && (cy_q == LAST_CY);
  assign colour  = COLOUR;
  assign x       = x_q;
  assign y       = y_q;

  // Candidate moved position; |step| < screen size so one correction always suffices.
  always_comb begin
    x_raw = $signed({2'b00, x_q}) + DX_S;
    y_raw = $signed({3'b000, y_q}) + DY_S;
    if (x_raw < 11'sd0)      x_wrap = 9'(x_raw + SW_S);
    else if (x_raw >= SW_S)  x_wrap = 9'(x_raw - SW_S);
    else                     x_wrap = 9'(x_raw);
    if (y_raw < 11'sd0)      y_wrap = 8'(y_raw + SH_S);
    else if (y_raw >= SH_S)  y_wrap = 8'(y_raw - SH_S);
    else                     y_wrap = 8'(y_raw);
  end

  // Next state: sweep counters advance while enabled; position only moves when idle.
  always_comb begin
    cx_d = 6'd0;
    cy_d = 6'd0;
    x_d  = x_q;
    y_d  = y_q;
    if (enable) begin
      if (cx_q != LAST_CX) begin
        cx_d = cx_q + 6'd1;
        cy_d = cy_q;
      end else begin
        cx_d = 6'd0;
        cy_d = (cy_q == LAST_CY) ? 6'd0 : cy_q + 6'd1;
      end
    end else if (can_move) begin
      x_d = x_wrap;
      y_d = y_wrap;
    end
  end

  // State registers with synchronous reset to the start position.
  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q <= 6'd0;
      cy_q <= 6'd0;
      x_q  <= X_RST;
      y_q  <= Y_RST;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

endmodule
